// File: rtl/demux_scan_if.sv
// Handshake and demux-drive signals between a word producer and demux_scan_ctrl.
interface demux_scan_if;
   logic       load_valid;
   logic [7:0] load_data;
   logic       load_ready;
   logic       abort;
   logic [2:0] sel;
   logic       dout;
   logic       busy;
   logic       frame_done;

   modport master (
      output load_valid, load_data, abort,
      input  load_ready, sel, dout, busy, frame_done
   );

   modport slave (
      input  load_valid, load_data, abort,
      output load_ready, sel, dout, busy, frame_done
   );
endinterface

// File: rtl/demux_scan_ctrl.sv
// Sequencer that latches an 8-bit word and walks it out one demux channel at a time,
// holding each channel for DWELL cycles, then pulses frame_done.
module demux_scan_ctrl #(
   parameter int unsigned DWELL     = 1,
   parameter int unsigned CNT_W     = 8,
   parameter bit          MSB_FIRST = 1'b0
) (
   input logic        clk,
   input logic        rst_n,
   demux_scan_if.slave bus
);

   localparam int unsigned      DWELL_EFF = (DWELL < 1) ? 1 : DWELL;
   localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(DWELL_EFF - 1);
   localparam logic [2:0]       START_CH  = MSB_FIRST ? 3'd7 : 3'd0;
   localparam logic [2:0]       LAST_CH   = MSB_FIRST ? 3'd0 : 3'd7;

   typedef enum logic {IDLE, SCAN} state_t;

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [7:0]       word, word_n;
   logic [2:0]       sel_r, sel_n;
   logic             dout_r, dout_n;
   logic             busy_r, busy_n;
   logic             fd_r, fd_n;
   logic             rdy_r, rdy_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         sel_r  <= 3'd0;
         dout_r <= 1'b0;
         busy_r <= 1'b0;
         fd_r   <= 1'b0;
         rdy_r  <= 1'b1;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         sel_r  <= sel_n;
         dout_r <= dout_n;
         busy_r <= busy_n;
         fd_r   <= fd_n;
         rdy_r  <= rdy_n;
      end
   end

   // Shadow word is pure data: it is only meaningful while SCAN is active.
   always_ff @(posedge clk) begin
      word <= word_n;
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      word_n  = word;
      sel_n   = sel_r;
      dout_n  = 1'b0;
      busy_n  = 1'b0;
      fd_n    = 1'b0;
      rdy_n   = 1'b1;
      case (state)
         IDLE: begin
            sel_n = START_CH;
            if (bus.load_valid && rdy_r) begin
               word_n  = bus.load_data;
               cnt_n   = '0;
               state_n = SCAN;
               dout_n  = bus.load_data[START_CH];
               busy_n  = 1'b1;
               rdy_n   = 1'b0;
            end
         end
         SCAN: begin
            busy_n = 1'b1;
            rdy_n  = 1'b0;
            dout_n = dout_r;
            // Abort wins over a dwell expiry landing on the same edge.
            if (bus.abort) begin
               state_n = IDLE;
               cnt_n   = '0;
               sel_n   = START_CH;
               dout_n  = 1'b0;
               busy_n  = 1'b0;
               rdy_n   = 1'b1;
            end else if (cnt == LAST_CNT) begin
               cnt_n = '0;
               if (sel_r == LAST_CH) begin
                  state_n = IDLE;
                  fd_n    = 1'b1;
                  sel_n   = START_CH;
                  dout_n  = 1'b0;
                  busy_n  = 1'b0;
                  rdy_n   = 1'b1;
               end else begin
                  sel_n  = MSB_FIRST ? (sel_r - 3'd1) : (sel_r + 3'd1);
                  dout_n = word[sel_n];
               end
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign bus.sel        = sel_r;
   assign bus.dout       = dout_r;
   assign bus.busy       = busy_r;
   assign bus.frame_done = fd_r;
   assign bus.load_ready = rdy_r;

endmodule

// File: tb/tb_demux_scan_ctrl.sv
// Scoreboard bench for demux_scan_ctrl across four DWELL/MSB_FIRST configurations.
module tb_demux_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   int         cfg = 0;
   logic       lv = 1'b0;
   logic       ab = 1'b0;
   logic [7:0] ld = 8'h00;
   logic       mon_en = 1'b0;

   always #5 clk = ~clk;

   demux_scan_if if0 ();
   demux_scan_if if1 ();
   demux_scan_if if2 ();
   demux_scan_if if3 ();

   assign if0.load_valid = lv && (cfg == 0);
   assign if1.load_valid = lv && (cfg == 1);
   assign if2.load_valid = lv && (cfg == 2);
   assign if3.load_valid = lv && (cfg == 3);
   assign if0.abort      = ab && (cfg == 0);
   assign if1.abort      = ab && (cfg == 1);
   assign if2.abort      = ab && (cfg == 2);
   assign if3.abort      = ab && (cfg == 3);
   assign if0.load_data  = ld;
   assign if1.load_data  = ld;
   assign if2.load_data  = ld;
   assign if3.load_data  = ld;

   demux_scan_ctrl #(.DWELL(1), .CNT_W(8), .MSB_FIRST(1'b0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
   demux_scan_ctrl #(.DWELL(3), .CNT_W(8), .MSB_FIRST(1'b0)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
   demux_scan_ctrl #(.DWELL(2), .CNT_W(8), .MSB_FIRST(1'b0)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
   demux_scan_ctrl #(.DWELL(1), .CNT_W(8), .MSB_FIRST(1'b1)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

   // Observed tuple {sel, dout, busy, frame_done, load_ready} of the active instance.
   logic [6:0] tup;
   always_comb begin
      tup = 7'd0;
      case (cfg)
         0: tup = {if0.sel, if0.dout, if0.busy, if0.frame_done, if0.load_ready};
         1: tup = {if1.sel, if1.dout, if1.busy, if1.frame_done, if1.load_ready};
         2: tup = {if2.sel, if2.dout, if2.busy, if2.frame_done, if2.load_ready};
         default: tup = {if3.sel, if3.dout, if3.busy, if3.frame_done, if3.load_ready};
      endcase
   end

   wire [2:0] o_sel  = tup[6:4];
   wire       o_busy = tup[2];
   wire       o_fd   = tup[1];
   wire       o_rdy  = tup[0];

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h (cfg=%0d t=%0t)", tag, act, exp, cfg, $time);
      end
   endtask

   function automatic int dw(input int c);
      case (c)
         1: return 3;
         2: return 2;
         default: return 1;
      endcase
   endfunction

   function automatic logic [2:0] start_ch(input int c);
      return (c == 3) ? 3'd7 : 3'd0;
   endfunction

   logic [6:0] exq[$];
   int         fd_t[$];
   int         cyc = 0;
   int         t_start = 0;
   int         t_fd = 0;
   logic       prev_busy = 1'b0;

   function automatic void push_frame(input logic [7:0] w);
      logic [2:0] ch;
      for (int i = 0; i < 8; i++) begin
         ch = (cfg == 3) ? 3'(7 - i) : 3'(i);
         for (int k = 0; k < dw(cfg); k++)
            exq.push_back({ch, w[ch], 1'b1, 1'b0, 1'b0});
      end
      exq.push_back({start_ch(cfg), 1'b0, 1'b0, 1'b1, 1'b1});
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial forever begin
      @(negedge clk);
      if (mon_en) begin
         if (o_busy && !prev_busy) t_start = cyc;
         prev_busy = o_busy;
         if (o_fd) begin
            t_fd = cyc;
            fd_t.push_back(cyc);
         end
         if (o_busy || o_fd || !o_rdy) begin
            if (exq.size() == 0)
               chk("spurious", 32'(tup), 32'({start_ch(cfg), 4'b0001}));
            else
               chk("scan", 32'(tup), 32'(exq.pop_front()));
         end
      end
   end

   task automatic send(input logic [7:0] w, input logic abort_too);
      int n;
      @(negedge clk);
      lv = 1'b1;
      ld = w;
      ab = abort_too;
      n = 0;
      while (!o_rdy && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("accept_rdy", 32'(o_rdy), 32'd1);
      push_frame(w);
      @(negedge clk);
      lv = 1'b0;
      ab = 1'b0;
      ld = ~w;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exq.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("drain", 32'(exq.size()), 32'd0);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int n;
      int gap;
      // Reset and idle
      repeat (3) @(negedge clk);
      chk("rst_hold", 32'(tup), 32'h01);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_idle", 32'(tup), 32'h01);
      mon_en = 1'b1;

      // DWELL=1 basic scan; abort high during the IDLE accept is ignored
      cfg = 0;
      send(8'hA5, 1'b1);
      drain();

      // DWELL=3 hold and frame latency
      cfg = 1;
      send(8'h01, 1'b0);
      drain();
      chk("dwell_lat", 32'(t_fd - t_start), 32'd24);

      // Back-to-back with load_valid held high
      cfg = 0;
      fd_t.delete();
      @(negedge clk);
      lv = 1'b1;
      ld = 8'hFF;
      chk("b2b_rdy", 32'(o_rdy), 32'd1);
      push_frame(8'hFF);
      @(negedge clk);
      ld = 8'h00;
      n = 0;
      while (!o_rdy && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("b2b_in_fd", 32'(o_fd), 32'd1);
      push_frame(8'h00);
      @(negedge clk);
      lv = 1'b0;
      drain();
      chk("fd_count", 32'(fd_t.size()), 32'd2);
      gap = (fd_t.size() >= 2) ? (fd_t[1] - fd_t[0]) : -1;
      chk("fd_gap", 32'(gap), 32'd9);

      // Abort coinciding with dwell expiry at sel=3, DWELL=2
      cfg = 2;
      fd_t.delete();
      @(negedge clk);
      lv = 1'b1;
      ld = 8'hFF;
      push_frame(8'hFF);
      @(negedge clk);
      lv = 1'b0;
      repeat (7) @(negedge clk);
      chk("abort_pt", 32'(o_sel), 32'd3);
      ab = 1'b1;
      @(posedge clk);
      #1;
      exq.delete();
      ab = 1'b0;
      chk("abort_idle", 32'(tup), 32'h01);
      repeat (20) @(negedge clk);
      chk("abort_no_fd", 32'(fd_t.size()), 32'd0);

      // MSB_FIRST scan
      cfg = 3;
      send(8'h80, 1'b0);
      drain();

      // Asynchronous reset mid-scan at sel=4
      @(negedge clk);
      lv = 1'b1;
      ld = 8'h5A;
      push_frame(8'h5A);
      @(negedge clk);
      lv = 1'b0;
      n = 0;
      while (o_sel != 3'd4 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("rst_pt", 32'(o_sel), 32'd4);
      #1;
      mon_en = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("async_rst", 32'(tup), 32'h01);
      exq.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      prev_busy = 1'b0;
      mon_en = 1'b1;
      send(8'h3C, 1'b0);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule
